// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown driven by the 1 Hz CE tick.
//
// Tick interface: CE is a one-cycle enable qualified only by clk. There is
// no ready/backpressure. Every cycle in which CE is high while the timer is
// RUN and not being paused spends exactly one second. CEO is the matching
// one-cycle enable emitted downstream on the cycle the count reaches 00:00.
//
// State encoding seen on state_dbg:
//   0 = IDLE, 1 = RUN, 2 = PAUSED, 3 = EXPIRED.
module countdown_timer #(
    parameter logic [7:0] MAX_MIN = 8'h99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CE,
    input  logic       load,
    input  logic [7:0] min_in,
    input  logic [7:0] sec_in,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic       running,
    output logic       expired,
    output logic       CEO,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       ceo_q, ceo_d;

    logic [7:0] load_min, load_sec;
    logic [7:0] dec_min, dec_sec;
    logic       count_zero, dec_zero, load_ok;

    // A BCD digit above 9 is read as 9.
    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Load sanitising. The range clamp looks at the raw value first, so an
    // out-of-range minutes value such as A7 becomes MAX_MIN rather than 97,
    // and a seconds tens digit above 5 becomes 59 whatever the ones digit is.
    // Only values that pass the range checks get per-digit saturation.
    always_comb begin
        if (min_in > MAX_MIN)
            load_min = MAX_MIN;
        else
            load_min = {sat_digit(min_in[7:4]), sat_digit(min_in[3:0])};

        if (sec_in[7:4] > 4'd5)
            load_sec = 8'h59;
        else
            load_sec = {sec_in[7:4], sat_digit(sec_in[3:0])};
    end

    // One-second BCD decrement with borrow chain sec ones -> sec tens ->
    // min ones -> min tens. It is only applied when the count is non-zero,
    // so a wrap below 00:00 is never stored.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_q[3:0] - 4'd1;
        end else begin
            dec_sec[3:0] = 4'd9;
            if (sec_q[7:4] != 4'd0) begin
                dec_sec[7:4] = sec_q[7:4] - 4'd1;
            end else begin
                dec_sec[7:4] = 4'd5;
                if (min_q[3:0] != 4'd0) begin
                    dec_min[3:0] = min_q[3:0] - 4'd1;
                end else begin
                    dec_min[3:0] = 4'd9;
                    dec_min[7:4] = min_q[7:4] - 4'd1;
                end
            end
        end
    end

    assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    assign dec_zero   = (dec_min == 8'h00) && (dec_sec == 8'h00);
    // Load is a no-op while running, so it must not preempt pause/CE there.
    assign load_ok    = load && (state_q != S_RUN);

    // Next-state and next-count logic. Priority: load > pause > start > CE.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        ceo_d   = 1'b0;
        if (load_ok) begin
            state_d = S_IDLE;
            min_d   = load_min;
            sec_d   = load_sec;
        end else begin
            case (state_q)
                S_IDLE, S_PAUSED: begin
                    // Starting from 00:00 would expire without a tick, so refuse it.
                    if (!pause && start && !count_zero)
                        state_d = S_RUN;
                end
                S_RUN: begin
                    if (pause) begin
                        // A CE in the same cycle is dropped on purpose.
                        state_d = S_PAUSED;
                    end else if (CE && !count_zero) begin
                        min_d = dec_min;
                        sec_d = dec_sec;
                        if (dec_zero) begin
                            state_d = S_EXPIRED;
                            ceo_d   = 1'b1;
                        end
                    end
                end
                S_EXPIRED: begin
                    // Hold 00:00 until a load arrives.
                    state_d = S_EXPIRED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, count and expiry-pulse registers. Reset is asynchronous, active low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            ceo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            ceo_q   <= ceo_d;
        end
    end

    assign min_out   = min_q;
    assign sec_out   = sec_q;
    assign CEO       = ceo_q;
    assign running   = (state_q == S_RUN);
    assign expired   = (state_q == S_EXPIRED);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer: one task per scenario, inline checks.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       CE;
    logic       load;
    logic [7:0] min_in;
    logic [7:0] sec_in;
    logic       start;
    logic       pause;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic       running;
    logic       expired;
    logic       CEO;
    logic [1:0] state_dbg;

    int n_cmp;
    int n_err;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    countdown_timer #(.MAX_MIN(8'h99)) dut (
        .clk       (clk),
        .reset     (reset),
        .CE        (CE),
        .load      (load),
        .min_in    (min_in),
        .sec_in    (sec_in),
        .start     (start),
        .pause     (pause),
        .min_out   (min_out),
        .sec_out   (sec_out),
        .running   (running),
        .expired   (expired),
        .CEO       (CEO),
        .state_dbg (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: hold the given inputs for one rising edge, then sample 1 ns later.
    task automatic cycle(input logic ce_v, input logic load_v, input logic start_v,
                         input logic pause_v, input logic [7:0] mi, input logic [7:0] si);
        CE     = ce_v;
        load   = load_v;
        start  = start_v;
        pause  = pause_v;
        min_in = mi;
        sec_in = si;
        @(posedge clk);
        #1;
        CE    = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            CE = i[0];
            @(posedge clk);
            #1;
        end
        CE = 1'b0;
        n_cmp++;
        if ({min_out, sec_out} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_count: got %h:%h want 00:00", min_out, sec_out);
        end
        n_cmp++;
        if ({running, expired, CEO, state_dbg} !== {3'b000, ST_IDLE}) begin
            n_err++;
            $display("FAIL reset_flags: got r=%b e=%b ceo=%b st=%0d want 0 0 0 0",
                     running, expired, CEO, state_dbg);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, state_dbg} !== {16'h0000, ST_IDLE}) begin
            n_err++;
            $display("FAIL ce_idle_after_reset: got %h:%h st=%0d want 00:00 st=0",
                     min_out, sec_out, state_dbg);
        end
    endtask

    task automatic test_basic_count();
        logic [15:0] exp_v[3];
        exp_v[0] = 16'h0059;
        exp_v[1] = 16'h0058;
        exp_v[2] = 16'h0057;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, state_dbg} !== {16'h0100, ST_IDLE}) begin
            n_err++;
            $display("FAIL load_0100: got %h:%h st=%0d want 01:00 st=0", min_out, sec_out, state_dbg);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({running, state_dbg} !== {1'b1, ST_RUN}) begin
            n_err++;
            $display("FAIL start_run: got r=%b st=%0d want r=1 st=1", running, state_dbg);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            n_cmp++;
            if ({min_out, sec_out, running} !== {exp_v[i], 1'b1}) begin
                n_err++;
                $display("FAIL basic_dec%0d: got %h:%h r=%b want %h r=1",
                         i, min_out, sec_out, running, exp_v[i]);
            end
        end
    endtask

    task automatic test_expiry();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, CEO, running} !== {16'h0001, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL expiry_0001: got %h:%h ceo=%b r=%b want 00:01 ceo=0 r=1",
                     min_out, sec_out, CEO, running);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, CEO, expired, running, state_dbg} !==
            {16'h0000, 3'b110, ST_EXPIRED}) begin
            n_err++;
            $display("FAIL expiry_hit: got %h:%h ceo=%b e=%b r=%b st=%0d want 00:00 1 1 0 st=3",
                     min_out, sec_out, CEO, expired, running, state_dbg);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, CEO, expired} !== {16'h0000, 2'b01}) begin
            n_err++;
            $display("FAIL expiry_pulse_once: got %h:%h ceo=%b e=%b want 00:00 ceo=0 e=1",
                     min_out, sec_out, CEO, expired);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, CEO, state_dbg} !== {16'h0000, 1'b0, ST_EXPIRED}) begin
            n_err++;
            $display("FAIL expiry_start_ignored: got %h:%h ceo=%b st=%0d want 00:00 0 st=3",
                     min_out, sec_out, CEO, state_dbg);
        end
    endtask

    task automatic test_borrow_pause();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, expired, state_dbg} !== {16'h1000, 1'b0, ST_IDLE}) begin
            n_err++;
            $display("FAIL load_from_expired: got %h:%h e=%b st=%0d want 10:00 e=0 st=0",
                     min_out, sec_out, expired, state_dbg);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out} !== 16'h0959) begin
            n_err++;
            $display("FAIL double_borrow: got %h:%h want 09:59", min_out, sec_out);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, running, state_dbg} !== {16'h0959, 1'b0, ST_PAUSED}) begin
            n_err++;
            $display("FAIL pause_drops_ce: got %h:%h r=%b st=%0d want 09:59 r=0 st=2",
                     min_out, sec_out, running, state_dbg);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out} !== 16'h0959) begin
            n_err++;
            $display("FAIL ce_in_paused: got %h:%h want 09:59", min_out, sec_out);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({running, state_dbg} !== {1'b1, ST_RUN}) begin
            n_err++;
            $display("FAIL resume: got r=%b st=%0d want r=1 st=1", running, state_dbg);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({min_out, sec_out} !== 16'h0958) begin
            n_err++;
            $display("FAIL resume_dec: got %h:%h want 09:58", min_out, sec_out);
        end
    endtask

    task automatic test_clamp();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hA7, 8'h7C);
        n_cmp++;
        if ({min_out, sec_out} !== 16'h9959) begin
            n_err++;
            $display("FAIL clamp_range: got %h:%h want 99:59", min_out, sec_out);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h3F, 8'h4B);
        n_cmp++;
        if ({min_out, sec_out} !== 16'h3949) begin
            n_err++;
            $display("FAIL clamp_digit: got %h:%h want 39:49", min_out, sec_out);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hA7, 8'h7C);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
        n_cmp++;
        if ({min_out, sec_out, running} !== {16'h9959, 1'b1}) begin
            n_err++;
            $display("FAIL load_in_run: got %h:%h r=%b want 99:59 r=1", min_out, sec_out, running);
        end
    endtask

    task automatic test_ce_held();
        logic [15:0] exp_v[3];
        exp_v[0] = 16'h0004;
        exp_v[1] = 16'h0003;
        exp_v[2] = 16'h0002;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        CE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({min_out, sec_out} !== exp_v[i]) begin
                n_err++;
                $display("FAIL ce_held%0d: got %h:%h want %h", i, min_out, sec_out, exp_v[i]);
            end
        end
        CE = 1'b0;
    endtask

    task automatic test_zero_start_and_reset_mid_run();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({running, state_dbg, min_out, sec_out} !== {1'b0, ST_IDLE, 16'h0000}) begin
            n_err++;
            $display("FAIL zero_start: got r=%b st=%0d %h:%h want r=0 st=0 00:00",
                     running, state_dbg, min_out, sec_out);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h30);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({min_out, sec_out, running, CEO, state_dbg} !== {16'h0000, 2'b00, ST_IDLE}) begin
            n_err++;
            $display("FAIL reset_mid_run: got %h:%h r=%b ceo=%b st=%0d want 00:00 0 0 st=0",
                     min_out, sec_out, running, CEO, state_dbg);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({CEO, expired, min_out, sec_out} !== {2'b00, 16'h0000}) begin
            n_err++;
            $display("FAIL no_ceo_after_reset: got ceo=%b e=%b %h:%h want 0 0 00:00",
                     CEO, expired, min_out, sec_out);
        end
    endtask

    // Sequencer and final report.
    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        CE     = 1'b0;
        load   = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        min_in = 8'h00;
        sec_in = 8'h00;
        #2;
        test_reset();
        test_basic_count();
        test_expiry();
        test_borrow_pause();
        test_clamp();
        test_ce_held();
        test_zero_start_and_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
